// File: rtl/mem_wb_if.sv
// Data-memory request/ready bus between the mem_wb stage (master) and data memory (slave).
// Vectors are big-endian ([0:N-1]) to match the rest of the ring-node CPU.
`timescale 1ns/1ps
interface mem_wb_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_wrEn;
    logic [0:ADDR_W-1] dmem_addr;
    logic [0:63]       dmem_wdata;
    logic [0:63]       dmem_rdata;
    logic              dmem_ready;

    modport master (
        output dmem_req,
        output dmem_wrEn,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_wrEn,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/mem_wb.sv
// Memory-access / writeback stage: runs loads/stores over a variable-latency handshake, stalls upstream meanwhile.
// Define MEM_WB_TIMEOUT_EN to add an access watchdog that aborts after TIMEOUT_CYCLES and sets sticky MEM_err.
`timescale 1ns/1ps
module mem_wb #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:4]        EX_MEM_rD,
    input  logic              EX_MEM_wrEn,
    input  logic [0:2]        EX_MEM_ppp,
    input  logic              EX_MEM_memEn,
    input  logic              EX_MEM_memwrEn,
    input  logic [0:ADDR_W-1] EX_MEM_addr,
    input  logic [0:63]       EX_MEM_data,
    mem_wb_if.master          dmem,
    output logic              MEM_stall,
    output logic [0:4]        WB_rD,
    output logic              WB_wrEn,
    output logic [0:2]        WB_ppp,
    output logic [0:63]       WB_rD_data,
    output logic              MEM_err
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [0:4] lat_rD;
    logic [0:2] lat_ppp;
    logic       lat_wrEn;
    logic       timeout;

`ifdef MEM_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;

    // Fires in the last permitted ACCESS cycle only when memory has still not answered.
    assign timeout = (state == ACCESS) && !dmem.dmem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            MEM_err  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (!dmem.dmem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                MEM_err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign MEM_err = 1'b0;
`endif

    assign MEM_stall = (state == ACCESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (EX_MEM_memEn) state_next = ACCESS;
            ACCESS:  if (dmem.dmem_ready || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The dmem_* flops double as the latched memwrEn/addr/data of the op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_wrEn  <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            lat_rD          <= '0;
            lat_ppp         <= '0;
            lat_wrEn        <= 1'b0;
            WB_rD           <= '0;
            WB_wrEn         <= 1'b0;
            WB_ppp          <= '0;
            WB_rD_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EX_MEM_memEn) begin
                        lat_rD          <= EX_MEM_rD;
                        lat_ppp         <= EX_MEM_ppp;
                        lat_wrEn        <= EX_MEM_wrEn;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_wrEn  <= EX_MEM_memwrEn;
                        dmem.dmem_addr  <= EX_MEM_addr;
                        dmem.dmem_wdata <= EX_MEM_data;
                        WB_wrEn         <= 1'b0;
                    end else begin
                        WB_rD      <= EX_MEM_rD;
                        WB_ppp     <= EX_MEM_ppp;
                        WB_rD_data <= EX_MEM_data;
                        WB_wrEn    <= EX_MEM_wrEn;
                    end
                end
                ACCESS: begin
                    WB_wrEn <= 1'b0;
                    if (dmem.dmem_ready) begin
                        dmem.dmem_req <= 1'b0;
                        if (!dmem.dmem_wrEn) begin
                            WB_rD_data <= dmem.dmem_rdata;
                            WB_rD      <= lat_rD;
                            WB_ppp     <= lat_ppp;
                            WB_wrEn    <= lat_wrEn;
                        end
                    end else if (timeout) begin
                        dmem.dmem_req <= 1'b0;
                    end
                end
                default: WB_wrEn <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: table-driven ALU ops plus directed load/store/stall/reset sequences.
// The watchdog sequence runs only when MEM_WB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
`timescale 1ns/1ps
module tb_mem_wb;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [0:4]  rD;
        logic        wrEn;
        logic [0:2]  ppp;
        logic [0:63] data;
        logic [0:4]  exp_rD;
        logic        exp_wrEn;
        logic [0:2]  exp_ppp;
        logic [0:63] exp_data;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [0:4]        EX_MEM_rD;
    logic              EX_MEM_wrEn;
    logic [0:2]        EX_MEM_ppp;
    logic              EX_MEM_memEn;
    logic              EX_MEM_memwrEn;
    logic [0:ADDR_W-1] EX_MEM_addr;
    logic [0:63]       EX_MEM_data;
    logic              MEM_stall;
    logic [0:4]        WB_rD;
    logic              WB_wrEn;
    logic [0:2]        WB_ppp;
    logic [0:63]       WB_rD_data;
    logic              MEM_err;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t vecs [4];

    mem_wb_if #(.ADDR_W(ADDR_W)) dmem ();

    mem_wb #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .EX_MEM_rD(EX_MEM_rD),
        .EX_MEM_wrEn(EX_MEM_wrEn),
        .EX_MEM_ppp(EX_MEM_ppp),
        .EX_MEM_memEn(EX_MEM_memEn),
        .EX_MEM_memwrEn(EX_MEM_memwrEn),
        .EX_MEM_addr(EX_MEM_addr),
        .EX_MEM_data(EX_MEM_data),
        .dmem(dmem),
        .MEM_stall(MEM_stall),
        .WB_rD(WB_rD),
        .WB_wrEn(WB_wrEn),
        .WB_ppp(WB_ppp),
        .WB_rD_data(WB_rD_data),
        .MEM_err(MEM_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [0:4] rD, input logic wrEn, input logic [0:2] ppp,
                                 input logic memEn, input logic memwrEn,
                                 input logic [0:ADDR_W-1] addr, input logic [0:63] data);
        EX_MEM_rD      = rD;
        EX_MEM_wrEn    = wrEn;
        EX_MEM_ppp     = ppp;
        EX_MEM_memEn   = memEn;
        EX_MEM_memwrEn = memwrEn;
        EX_MEM_addr    = addr;
        EX_MEM_data    = data;
    endtask

    task automatic applyIdle();
        applyStimulus(5'd0, 1'b0, 3'd0, 1'b0, 1'b0, '0, 64'd0);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"},   64'(dmem.dmem_req),   64'd0);
        checkOutput({tag, "_dwr"},   64'(dmem.dmem_wrEn),  64'd0);
        checkOutput({tag, "_addr"},  64'(dmem.dmem_addr),  64'd0);
        checkOutput({tag, "_wdata"}, 64'(dmem.dmem_wdata), 64'd0);
        checkOutput({tag, "_stall"}, 64'(MEM_stall),       64'd0);
        checkOutput({tag, "_wbrd"},  64'(WB_rD),           64'd0);
        checkOutput({tag, "_wbwr"},  64'(WB_wrEn),         64'd0);
        checkOutput({tag, "_wbppp"}, 64'(WB_ppp),          64'd0);
        checkOutput({tag, "_wbdat"}, 64'(WB_rD_data),      64'd0);
        checkOutput({tag, "_err"},   64'(MEM_err),         64'd0);
    endtask

    initial begin
        vecs[0] = '{5'd5,  1'b1, 3'b000, 64'h0123456789ABCDEF, 5'd5,  1'b1, 3'b000, 64'h0123456789ABCDEF};
        vecs[1] = '{5'd0,  1'b1, 3'b101, 64'hFFFFFFFFFFFFFFFF, 5'd0,  1'b1, 3'b101, 64'hFFFFFFFFFFFFFFFF};
        vecs[2] = '{5'd31, 1'b0, 3'b010, 64'h8000000000000001, 5'd31, 1'b0, 3'b010, 64'h8000000000000001};
        vecs[3] = '{5'd12, 1'b1, 3'b111, 64'h000000000000002A, 5'd12, 1'b1, 3'b111, 64'h000000000000002A};

        reset            = 1'b1;
        dmem.dmem_ready  = 1'b0;
        dmem.dmem_rdata  = 64'd0;
        applyIdle();
        #11;
        checkAllZero("por");
        #1 reset = 1'b0;
        tick();

        // ALU ops retire one cycle after acceptance with no stall.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].rD, vecs[i].wrEn, vecs[i].ppp, 1'b0, 1'b0, '0, vecs[i].data);
            tick();
            checkOutput($sformatf("alu%0d_rd", i),    64'(WB_rD),      64'(vecs[i].exp_rD));
            checkOutput($sformatf("alu%0d_wr", i),    64'(WB_wrEn),    64'(vecs[i].exp_wrEn));
            checkOutput($sformatf("alu%0d_ppp", i),   64'(WB_ppp),     64'(vecs[i].exp_ppp));
            checkOutput($sformatf("alu%0d_data", i),  64'(WB_rD_data), 64'(vecs[i].exp_data));
            checkOutput($sformatf("alu%0d_stall", i), 64'(MEM_stall),  64'd0);
        end

        // Asynchronous reset mid-cycle clears the last ALU writeback immediately.
        #2 reset = 1'b1;
        #1 checkAllZero("async_rst");
        applyIdle();
        #1 reset = 1'b0;
        tick();

        // Load rD=7 @0x40, ready in the 3rd ACCESS cycle.
        applyStimulus(5'd7, 1'b1, 3'b001, 1'b1, 1'b0, 32'h40, 64'd0);
        tick();
        applyIdle();
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("ld_req_c%0d", k),   64'(dmem.dmem_req),  64'd1);
            checkOutput($sformatf("ld_stall_c%0d", k), 64'(MEM_stall),      64'd1);
            checkOutput($sformatf("ld_dwr_c%0d", k),   64'(dmem.dmem_wrEn), 64'd0);
            checkOutput($sformatf("ld_addr_c%0d", k),  64'(dmem.dmem_addr), 64'h40);
            checkOutput($sformatf("ld_wbwr_c%0d", k),  64'(WB_wrEn),        64'd0);
            if (k == 3) begin
                dmem.dmem_ready = 1'b1;
                dmem.dmem_rdata = 64'hDEADBEEFCAFEF00D;
            end
            tick();
        end
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 64'd0;
        checkOutput("ld_wb_wr",   64'(WB_wrEn),       64'd1);
        checkOutput("ld_wb_rd",   64'(WB_rD),         64'd7);
        checkOutput("ld_wb_ppp",  64'(WB_ppp),        64'b001);
        checkOutput("ld_wb_data", 64'(WB_rD_data),    64'hDEADBEEFCAFEF00D);
        checkOutput("ld_done_st", 64'(MEM_stall),     64'd0);
        checkOutput("ld_done_rq", 64'(dmem.dmem_req), 64'd0);
        tick();
        checkOutput("ld_wb_once", 64'(WB_wrEn), 64'd0);

        // Store @0x80 data 0x1111 with single-cycle ready.
        applyStimulus(5'd2, 1'b0, 3'b000, 1'b1, 1'b1, 32'h80, 64'h1111);
        tick();
        applyIdle();
        checkOutput("st_req",   64'(dmem.dmem_req),   64'd1);
        checkOutput("st_dwr",   64'(dmem.dmem_wrEn),  64'd1);
        checkOutput("st_addr",  64'(dmem.dmem_addr),  64'h80);
        checkOutput("st_wdata", 64'(dmem.dmem_wdata), 64'h1111);
        checkOutput("st_stall", 64'(MEM_stall),       64'd1);
        dmem.dmem_ready = 1'b1;
        tick();
        dmem.dmem_ready = 1'b0;
        checkOutput("st_req_off", 64'(dmem.dmem_req), 64'd0);
        checkOutput("st_stall0",  64'(MEM_stall),     64'd0);
        checkOutput("st_wbwr",    64'(WB_wrEn),       64'd0);
        tick();
        checkOutput("st_wbwr2",   64'(WB_wrEn),       64'd0);

        // Load then ALU rD=9 held under stall: WB of the ALU op exactly one cycle after the load's.
        applyStimulus(5'd4, 1'b1, 3'b010, 1'b1, 1'b0, 32'h44, 64'd0);
        tick();
        applyStimulus(5'd9, 1'b1, 3'b011, 1'b0, 1'b0, '0, 64'h99);
        for (int k = 1; k <= 2; k++) begin
            checkOutput($sformatf("hold_stall_c%0d", k), 64'(MEM_stall), 64'd1);
            checkOutput($sformatf("hold_wbwr_c%0d", k),  64'(WB_wrEn),   64'd0);
            if (k == 2) begin
                dmem.dmem_ready = 1'b1;
                dmem.dmem_rdata = 64'hA5A5A5A55A5A5A5A;
            end
            tick();
        end
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 64'd0;
        checkOutput("hold_ld_wr",   64'(WB_wrEn),    64'd1);
        checkOutput("hold_ld_rd",   64'(WB_rD),      64'd4);
        checkOutput("hold_ld_data", 64'(WB_rD_data), 64'hA5A5A5A55A5A5A5A);
        tick();
        applyIdle();
        checkOutput("hold_alu_wr",   64'(WB_wrEn),    64'd1);
        checkOutput("hold_alu_rd",   64'(WB_rD),      64'd9);
        checkOutput("hold_alu_ppp",  64'(WB_ppp),     64'b011);
        checkOutput("hold_alu_data", 64'(WB_rD_data), 64'h99);
        tick();
        checkOutput("hold_alu_once", 64'(WB_wrEn),    64'd0);

        // Reset while an access is outstanding drops the request at once.
        applyStimulus(5'd6, 1'b1, 3'b000, 1'b1, 1'b0, 32'h48, 64'd0);
        tick();
        applyIdle();
        checkOutput("mid_rst_req_pre", 64'(dmem.dmem_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_req",   64'(dmem.dmem_req),  64'd0);
        checkOutput("mid_rst_stall", 64'(MEM_stall),      64'd0);
        checkOutput("mid_rst_wbwr",  64'(WB_wrEn),        64'd0);
        checkOutput("mid_rst_addr",  64'(dmem.dmem_addr), 64'd0);
        #1 reset = 1'b0;
        tick();
        checkOutput("post_rst_stall", 64'(MEM_stall), 64'd0);
        checkOutput("post_rst_wbwr",  64'(WB_wrEn),   64'd0);

`ifdef MEM_WB_TIMEOUT_EN
        // No ready for 4 ACCESS cycles: abort, sticky error, no writeback.
        applyStimulus(5'd8, 1'b1, 3'b000, 1'b1, 1'b0, 32'h50, 64'd0);
        tick();
        applyIdle();
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("to_stall_c%0d", k), 64'(MEM_stall), 64'd1);
            checkOutput($sformatf("to_err_c%0d", k),   64'(MEM_err),   64'd0);
            tick();
        end
        checkOutput("to_err",   64'(MEM_err),       64'd1);
        checkOutput("to_stall", 64'(MEM_stall),     64'd0);
        checkOutput("to_req",   64'(dmem.dmem_req), 64'd0);
        checkOutput("to_wbwr",  64'(WB_wrEn),       64'd0);
        tick();
        checkOutput("to_sticky", 64'(MEM_err), 64'd1);

        // Ready in the final permitted cycle still completes normally.
        applyStimulus(5'd10, 1'b1, 3'b000, 1'b1, 1'b0, 32'h54, 64'd0);
        tick();
        applyIdle();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                dmem.dmem_ready = 1'b1;
                dmem.dmem_rdata = 64'h0000000012345678;
            end
            tick();
        end
        dmem.dmem_ready = 1'b0;
        checkOutput("to_last_wr",   64'(WB_wrEn),    64'd1);
        checkOutput("to_last_data", 64'(WB_rD_data), 64'h0000000012345678);
        #2 reset = 1'b1;
        #1 checkOutput("to_err_rst", 64'(MEM_err), 64'd0);
        #1 reset = 1'b0;
        tick();
`else
        // Without the watchdog an access waits as long as memory takes.
        applyStimulus(5'd8, 1'b1, 3'b000, 1'b1, 1'b0, 32'h50, 64'd0);
        tick();
        applyIdle();
        for (int k = 1; k <= 12; k++) begin
            checkOutput($sformatf("wait_stall_c%0d", k), 64'(MEM_stall),     64'd1);
            checkOutput($sformatf("wait_req_c%0d", k),   64'(dmem.dmem_req), 64'd1);
            checkOutput($sformatf("wait_err_c%0d", k),   64'(MEM_err),       64'd0);
            if (k == 12) begin
                dmem.dmem_ready = 1'b1;
                dmem.dmem_rdata = 64'h0000000012345678;
            end
            tick();
        end
        dmem.dmem_ready = 1'b0;
        checkOutput("wait_wb_wr",   64'(WB_wrEn),    64'd1);
        checkOutput("wait_wb_rd",   64'(WB_rD),      64'd8);
        checkOutput("wait_wb_data", 64'(WB_rD_data), 64'h0000000012345678);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
